// File: rtl/write_back_fetch_gen.sv
// Write-back/fetch stage: merges ALU results with multi-beat sized loads and owns the fetch PC.
// Single-beat loads are combinational; a word load completes in its last beat. load_busy_o stalls upstream.
module write_back_fetch_gen #(
  parameter int XLEN    = 32,
  parameter int BUS_W   = 16,
  parameter int PC_STEP = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_to_reg_i,
  input  logic [1:0]        load_size_i,
  input  logic              load_signed_i,
  input  logic [BUS_W-1:0]  data_read_i,
  input  logic [XLEN-1:0]   data_calc_i,
  output logic [XLEN-1:0]   write_back_o,
  output logic              wb_valid_o,
  output logic              load_busy_o,
  input  logic              instr_mem_en_i,
  input  logic              stall_fetch_i,
  input  logic              stall_pc_i,
  input  logic              branch_i,
  input  logic [XLEN-1:0]   branch_pc_i,
  output logic              instr_mem_re_o,
  output logic [XLEN-1:0]   instr_mem_addr_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   next_pc_o
);
  localparam int BEATS = XLEN / BUS_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int ACC_W = XLEN - BUS_W;
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(PC_STEP - 1));
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic              w_load;
  logic              w_word;
  logic [XLEN-1:0]   w_ext;

  // Loads are ignored while reset is held so outputs track data_calc_i.
  assign w_load = mem_to_reg_i & rst_ni;
  assign w_word = load_size_i[1];

  always_comb begin
    if (load_size_i[0])
      w_ext = {{(XLEN-16){load_signed_i & data_read_i[15]}}, data_read_i[15:0]};
    else
      w_ext = {{(XLEN-8){load_signed_i & data_read_i[7]}}, data_read_i[7:0]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    write_back_o = data_calc_i;
    wb_valid_o   = 1'b1;
    load_busy_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          if (w_word) begin
            w_acc_nxt[BUS_W-1:0] = data_read_i;
            w_cnt_nxt            = CNT_W'(1);
            w_state_nxt          = S_COLLECT;
            wb_valid_o           = 1'b0;
            load_busy_o          = 1'b1;
          end else begin
            write_back_o = w_ext;
          end
        end
      end
      S_COLLECT: begin
        // A dropped mem_to_reg_i abandons the partial load.
        if (!w_load) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST_BEAT) begin
          write_back_o = {data_read_i, r_acc};
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
        end else begin
          for (int b = 1; b < BEATS - 1; b++) begin
            if (r_cnt == CNT_W'(b)) w_acc_nxt[b*BUS_W +: BUS_W] = data_read_i;
          end
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          wb_valid_o  = 1'b0;
          load_busy_o = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  logic            r_pend_v;
  logic [XLEN-1:0] r_pc, r_pend_pc;
  logic            w_pc_en;
  logic [XLEN-1:0] w_branch_al, w_tgt;

  assign w_pc_en     = instr_mem_en_i & ~stall_pc_i;
  assign w_branch_al = branch_pc_i & ALIGN_MASK;
  assign w_tgt       = branch_i ? w_branch_al : (r_pend_v ? r_pend_pc : r_pc + STEP);

  assign instr_mem_re_o   = ~stall_fetch_i;
  assign instr_mem_addr_o = (w_pc_en & instr_mem_re_o) ? w_tgt : r_pc;
  assign next_pc_o        = w_tgt + STEP;
  assign pc_o             = r_pc;

  // A redirect seen while the PC is held is latched; the newest one wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc      <= RESET_PC;
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
    end else if (w_pc_en) begin
      r_pc     <= w_tgt;
      r_pend_v <= 1'b0;
    end else if (branch_i) begin
      r_pend_pc <= w_branch_al;
      r_pend_v  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_write_back_fetch_gen.sv
// Bench for write_back_fetch_gen: directed scenarios plus random traffic checked against a queue-based model.
module tb_write_back_fetch_gen;
  localparam int BEATS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mtr, ld_sgn, ien, st_fetch, st_pc, br;
  logic [1:0]  ld_size;
  logic [15:0] d_rd;
  logic [31:0] d_calc, br_pc;
  logic [31:0] wb, addr, pc, npc;
  logic        wb_v, busy, re;

  always #5 clk = ~clk;

  write_back_fetch_gen dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_to_reg_i(mtr), .load_size_i(ld_size), .load_signed_i(ld_sgn),
    .data_read_i(d_rd), .data_calc_i(d_calc),
    .write_back_o(wb), .wb_valid_o(wb_v), .load_busy_o(busy),
    .instr_mem_en_i(ien), .stall_fetch_i(st_fetch), .stall_pc_i(st_pc),
    .branch_i(br), .branch_pc_i(br_pc),
    .instr_mem_re_o(re), .instr_mem_addr_o(addr), .pc_o(pc), .next_pc_o(npc)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: beats collected so far and the fetch PC with its pending redirect.
  logic [15:0] m_q[$];
  logic [15:0] n_q[$];
  logic [31:0] m_pc, m_ppc, n_pc, n_ppc;
  bit          m_pv, n_pv;

  task automatic model_reset();
    m_q.delete();
    m_pc  = 32'h0;
    m_ppc = 32'h0;
    m_pv  = 1'b0;
  endtask

  function automatic logic [31:0] extend(input logic [15:0] d, input bit half, input bit sgn);
    logic [31:0] v;
    if (half) begin
      v = {16'h0, d};
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = {16'h0, d} & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end
    return v;
  endfunction

  task automatic settle();
    logic [31:0] e_wb, tgt, e_addr;
    bit e_v, e_b, en;
    @(negedge clk);
    e_wb = d_calc; e_v = 1'b1; e_b = 1'b0;
    n_q = m_q;
    if (!rst_n || !mtr) begin
      n_q.delete();
    end else if (m_q.size() == 0 && ld_size < 2'd2) begin
      e_wb = extend(d_rd, ld_size[0], ld_sgn);
    end else begin
      n_q.push_back(d_rd);
      if (n_q.size() == BEATS) begin
        e_wb = 32'h0;
        foreach (n_q[i]) e_wb = e_wb | (32'(n_q[i]) << (16 * i));
        n_q.delete();
      end else begin
        e_v = 1'b0; e_b = 1'b1;
      end
    end
    check_eq("wb_valid", 32'(wb_v), 32'(e_v));
    check_eq("load_busy", 32'(busy), 32'(e_b));
    if (e_v) check_eq("write_back", wb, e_wb);

    en     = ien && !st_pc;
    tgt    = br ? (br_pc & ~32'h1) : (m_pv ? m_ppc : m_pc + 32'd2);
    e_addr = (en && !st_fetch) ? tgt : m_pc;
    check_eq("instr_re", 32'(re), 32'(!st_fetch));
    check_eq("instr_addr", addr, e_addr);
    check_eq("next_pc", npc, tgt + 32'd2);
    check_eq("pc", pc, m_pc);
    n_pc = m_pc; n_pv = m_pv; n_ppc = m_ppc;
    if (en) begin
      n_pc = tgt; n_pv = 1'b0;
    end else if (br) begin
      n_ppc = br_pc & ~32'h1; n_pv = 1'b1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      m_q = n_q; m_pc = n_pc; m_pv = n_pv; m_ppc = n_ppc;
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic idle_inputs();
    mtr = 0; ld_size = 2'd0; ld_sgn = 0; d_rd = 16'h0; d_calc = 32'h1234_5678;
    ien = 1; st_fetch = 0; st_pc = 0; br = 0; br_pc = 32'h0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(wb_v), 32'd1);
    check_eq("rst_wb", wb, 32'h1234_5678);
    check_eq("rst_pc", pc, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      settle();
      check_eq("fetch_seq_addr", addr, 32'(2 * i));
      check_eq("fetch_seq_next", npc, 32'(2 * i + 2));
      advance();
    end

    mtr = 1; ld_size = 2'b10; d_rd = 16'hBEEF;
    settle();
    check_eq("word_b1_busy", 32'(busy), 32'd1);
    check_eq("word_b1_valid", 32'(wb_v), 32'd0);
    advance();
    d_rd = 16'hDEAD;
    settle();
    check_eq("word_b2_wb", wb, 32'hDEADBEEF);
    check_eq("word_b2_valid", 32'(wb_v), 32'd1);
    advance();

    ld_size = 2'b00; d_rd = 16'h0080; ld_sgn = 1;
    settle();
    check_eq("byte_signed", wb, 32'hFFFF_FF80);
    advance();
    ld_sgn = 0;
    settle();
    check_eq("byte_unsigned", wb, 32'h0000_0080);
    check_eq("byte_valid", 32'(wb_v), 32'd1);
    advance();
    mtr = 0;

    st_pc = 1; br = 1; br_pc = 32'h101;
    settle(); advance();
    st_pc = 0; br = 0;
    settle();
    check_eq("pend_addr", addr, 32'h100);
    advance();
    check_eq("pend_pc", pc, 32'h100);
    st_pc = 1; br = 1; br_pc = 32'h101;
    settle(); advance();
    br_pc = 32'h200;
    settle(); advance();
    st_pc = 0; br = 0;
    settle();
    check_eq("pend_newer_addr", addr, 32'h200);
    advance();

    mtr = 1; ld_size = 2'b10; d_rd = 16'h1234;
    settle(); advance();
    mtr = 0; d_calc = 32'hCAFE_0000;
    settle();
    check_eq("abort_wb", wb, 32'hCAFE_0000);
    check_eq("abort_valid", 32'(wb_v), 32'd1);
    advance();
    mtr = 1; ld_size = 2'b01; ld_sgn = 1; d_rd = 16'h8001;
    settle();
    check_eq("half_after_abort", wb, 32'hFFFF_8001);
    advance();

    for (int c = 0; c < 600; c++) begin
      mtr      = ($urandom % 3) != 0;
      ld_size  = 2'($urandom % 4);
      ld_sgn   = 1'($urandom % 2);
      d_rd     = 16'($urandom);
      d_calc   = $urandom;
      ien      = ($urandom % 4) != 0;
      st_fetch = ($urandom % 5) == 0;
      st_pc    = ($urandom % 4) == 0;
      br       = ($urandom % 8) == 0;
      br_pc    = $urandom;
      settle(); advance();
    end

    idle_inputs();
    mtr = 1; ld_size = 2'b10; d_rd = 16'hAAAA;
    settle(); advance();
    settle(); advance();
    settle(); advance();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_pc", pc, 32'h0);
    settle(); advance();
    rst_n = 1'b1;
    mtr = 0;
    settle();
    check_eq("post_rst_addr", addr, 32'h2);
    advance();
    settle();
    check_eq("post_rst_pc", pc, 32'h2);
    advance();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
